// File: rtl/dpram_pkg.sv
// Shared constants and byte-lane merge helper for the parametrised dual-port RAM.
// Pure package: no latency, no flow control.
package dpram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers cast to and from their own width.
    localparam int MERGE_W  = 1024;
    localparam int MERGE_BE = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] merge(
        input logic [MERGE_W-1:0]  old_w,
        input logic [MERGE_W-1:0]  new_w,
        input logic [MERGE_BE-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int k = 0; k < MERGE_BE; k++) begin
            if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_if.sv
// One RAM access port: request fields from the agent, read data and valid back.
// No handshake: the RAM accepts a request every cycle, so there is no backpressure.
interface dpram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic                  en;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     adr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     q;
    logic                  vld;

    modport master (output en, we, be, adr, data, input q, vld);
    modport slave  (input en, we, be, adr, data, output q, vld);
endinterface

// File: rtl/dpram_out_stage.sv
// Read-data register plus optional second output register, with a matching vld pipeline.
// Latency 1 (OUT_REG=0) or 2 (OUT_REG=1); never stalls, data holds while no valid read arrives.
module dpram_out_stage #(
    parameter int DATA_W  = 8,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_dat,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_dat
);
    logic              r_vld;
    logic [DATA_W-1:0] r_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) r_dat <= i_dat;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_vld2;
            logic [DATA_W-1:0] r_dat2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld2 <= 1'b0;
                    r_dat2 <= '0;
                end else begin
                    r_vld2 <= r_vld;
                    if (r_vld) r_dat2 <= r_dat;
                end
            end

            assign o_vld = r_vld2;
            assign o_dat = r_dat2;
        end else begin : g_no_out_reg
            assign o_vld = r_vld;
            assign o_dat = r_dat;
        end
    endgenerate

endmodule

// File: rtl/dual_port_ram_param.sv
// True dual-port synchronous RAM with byte-lane writes, selectable same-port RDW and collision flag.
// Read latency 1 or 2 (OUT_REG); both ports accept an access every cycle, no backpressure.
module dual_port_ram_param
    import dpram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int RDW_MODE = RDW_READ_FIRST,
    parameter int OUT_REG  = 0
) (
    input  logic   clk,
    input  logic   rst,
    dpram_if.slave p1,
    dpram_if.slave p2,
    output logic   collision
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic              r_coll;

    logic              w_wr1, w_wr2, w_coll;
    logic [DATA_W-1:0] w_old1, w_old2, w_new1, w_new2, w_rd1, w_rd2;
    logic [DATA_W-1:0] w_q1, w_q2;
    logic              w_vld1, w_vld2;

    function automatic logic [DATA_W-1:0] mrg(
        input logic [DATA_W-1:0] o,
        input logic [DATA_W-1:0] n,
        input logic [NB-1:0]     b
    );
        return DATA_W'(merge(MERGE_W'(o), MERGE_W'(n), MERGE_BE'(b)));
    endfunction

    assign w_wr1  = p1.en && p1.we && !rst;
    assign w_wr2  = p2.en && p2.we && !rst;
    assign w_coll = w_wr1 && w_wr2 && (p1.adr == p2.adr);

    assign w_old1 = r_mem[p1.adr];
    assign w_old2 = r_mem[p2.adr];

    // On a collision both ports share one final word in which port 1 owns every lane it enables.
    assign w_new1 = w_coll ? mrg(mrg(w_old1, p2.data, p2.be), p1.data, p1.be)
                           : mrg(w_old1, p1.data, p1.be);
    assign w_new2 = w_coll ? w_new1 : mrg(w_old2, p2.data, p2.be);

    // Only a port's own write can bypass; reads of the other port's write address see old data.
    assign w_rd1 = (RDW_MODE == RDW_WRITE_FIRST && w_wr1) ? w_new1 : w_old1;
    assign w_rd2 = (RDW_MODE == RDW_WRITE_FIRST && w_wr2) ? w_new2 : w_old2;

    always_ff @(posedge clk) begin
        if (w_wr1) r_mem[p1.adr] <= w_new1;
        if (w_wr2 && !w_coll) r_mem[p2.adr] <= w_new2;
    end

    always_ff @(posedge clk) begin
        if (rst) r_coll <= 1'b0;
        else     r_coll <= w_coll;
    end

    assign collision = r_coll;

    dpram_out_stage #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_out1 (
        .clk   (clk),
        .rst   (rst),
        .i_vld (p1.en && !rst),
        .i_dat (w_rd1),
        .o_vld (w_vld1),
        .o_dat (w_q1)
    );

    dpram_out_stage #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_out2 (
        .clk   (clk),
        .rst   (rst),
        .i_vld (p2.en && !rst),
        .i_dat (w_rd2),
        .o_vld (w_vld2),
        .o_dat (w_q2)
    );

    assign p1.q   = w_q1;
    assign p1.vld = w_vld1;
    assign p2.q   = w_q2;
    assign p2.vld = w_vld2;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench: 8-bit RAM as read-first/latency-1 (u_a) and write-first/latency-2 (u_b) on
// identical stimulus, plus a 16-bit read-first RAM (u_w) for byte lanes and collisions.
module tb_dual_port_ram_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic coll_a, coll_b, coll_w;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dpram_if #(.DATA_W(8),  .ADDR_W(6)) ia1 (), ia2 (), ib1 (), ib2 ();
    dpram_if #(.DATA_W(16), .ADDR_W(6)) iw1 (), iw2 ();

    assign ib1.en = ia1.en;  assign ib1.we = ia1.we;  assign ib1.be = ia1.be;
    assign ib1.adr = ia1.adr; assign ib1.data = ia1.data;
    assign ib2.en = ia2.en;  assign ib2.we = ia2.we;  assign ib2.be = ia2.be;
    assign ib2.adr = ia2.adr; assign ib2.data = ia2.data;

    dual_port_ram_param #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0), .OUT_REG(0)) u_a (
        .clk(clk), .rst(rst), .p1(ia1), .p2(ia2), .collision(coll_a));
    dual_port_ram_param #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(1), .OUT_REG(1)) u_b (
        .clk(clk), .rst(rst), .p1(ib1), .p2(ib2), .collision(coll_b));
    dual_port_ram_param #(.DATA_W(16), .ADDR_W(6), .RDW_MODE(0), .OUT_REG(0)) u_w (
        .clk(clk), .rst(rst), .p1(iw1), .p2(iw2), .collision(coll_w));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv1(input logic en, input logic we, input logic [5:0] adr, input logic [7:0] d);
        ia1.en = en; ia1.we = we; ia1.be = 1'b1; ia1.adr = adr; ia1.data = d;
    endtask

    task automatic drv2(input logic en, input logic we, input logic [5:0] adr, input logic [7:0] d);
        ia2.en = en; ia2.we = we; ia2.be = 1'b1; ia2.adr = adr; ia2.data = d;
    endtask

    task automatic drvw1(input logic en, input logic we, input logic [1:0] be,
                         input logic [5:0] adr, input logic [15:0] d);
        iw1.en = en; iw1.we = we; iw1.be = be; iw1.adr = adr; iw1.data = d;
    endtask

    task automatic drvw2(input logic en, input logic we, input logic [1:0] be,
                         input logic [5:0] adr, input logic [15:0] d);
        iw2.en = en; iw2.we = we; iw2.be = be; iw2.adr = adr; iw2.data = d;
    endtask

    initial begin
        drv1(0, 0, 6'h00, 8'h00); drv2(0, 0, 6'h00, 8'h00);
        drvw1(0, 0, 2'b00, 6'h00, 16'h0); drvw2(0, 0, 2'b00, 6'h00, 16'h0);
        rst = 1'b1;
        tick(); tick();
        chk("rst_a_q1", ia1.q, 8'h00);   chk("rst_a_vld1", ia1.vld, 1'b0);
        chk("rst_a_q2", ia2.q, 8'h00);   chk("rst_a_vld2", ia2.vld, 1'b0);
        chk("rst_a_coll", coll_a, 1'b0);
        chk("rst_b_q1", ib1.q, 8'h00);   chk("rst_b_vld1", ib1.vld, 1'b0);
        chk("rst_w_coll", coll_w, 1'b0);
        rst = 1'b0;

        // T1: simultaneous writes to different addresses
        drv1(1, 1, 6'h01, 8'h33); drv2(1, 1, 6'h02, 8'h44);
        tick();
        chk("t1_a_coll", coll_a, 1'b0);
        chk("t1_a_vld1", ia1.vld, 1'b1);
        // T2: clear 0x03
        drv1(1, 1, 6'h03, 8'h00); drv2(0, 0, 6'h00, 8'h00);
        tick();
        chk("t1_b_wf_q1", ib1.q, 8'h33); chk("t1_b_vld1", ib1.vld, 1'b1);
        chk("t1_b_wf_q2", ib2.q, 8'h44); chk("t1_b_vld2", ib2.vld, 1'b1);
        // T3: cross reads
        drv1(1, 0, 6'h02, 8'h00); drv2(1, 0, 6'h01, 8'h00);
        tick();
        chk("t3_a_q2", ia2.q, 8'h33); chk("t3_a_vld2", ia2.vld, 1'b1);
        chk("t3_a_q1", ia1.q, 8'h44); chk("t3_a_vld1", ia1.vld, 1'b1);
        chk("t2_b_wf_q1", ib1.q, 8'h00); chk("t2_b_vld2", ib2.vld, 1'b0);
        // T4: port 1 writes 0x55@03 while port 2 reads 0x03
        drv1(1, 1, 6'h03, 8'h55); drv2(1, 0, 6'h03, 8'h00);
        tick();
        chk("t4_a_cross_q2", ia2.q, 8'h00);
        chk("t4_a_rf_q1", ia1.q, 8'h00);
        chk("t3_b_q1", ib1.q, 8'h44); chk("t3_b_q2", ib2.q, 8'h33);
        // T5: re-read 0x03 on port 2, port 1 idle
        drv1(0, 0, 6'h00, 8'h00); drv2(1, 0, 6'h03, 8'h00);
        tick();
        chk("t5_a_q2", ia2.q, 8'h55);
        chk("t5_a_vld1", ia1.vld, 1'b0); chk("t5_a_hold_q1", ia1.q, 8'h00);
        chk("t4_b_wf_q1", ib1.q, 8'h55);
        chk("t4_b_cross_q2", ib2.q, 8'h00);
        // T6: idle
        drv2(0, 0, 6'h00, 8'h00);
        tick();
        chk("t5_b_q2", ib2.q, 8'h55);
        chk("t5_b_vld1", ib1.vld, 1'b0); chk("t5_b_hold_q1", ib1.q, 8'h55);
        // T7: overwrite 0x44@02 with 0x77
        drv1(1, 1, 6'h02, 8'h77);
        tick();
        chk("t7_a_rf_q1", ia1.q, 8'h44); chk("t7_a_vld1", ia1.vld, 1'b1);
        drv1(0, 0, 6'h00, 8'h00);
        tick();
        chk("t7_b_wf_q1", ib1.q, 8'h77); chk("t7_b_vld1", ib1.vld, 1'b1);

        // Hold while disabled after reading 0x55
        drv1(1, 0, 6'h03, 8'h00);
        tick();
        chk("hold_a_q1_rd", ia1.q, 8'h55); chk("hold_a_vld1_rd", ia1.vld, 1'b1);
        drv1(0, 0, 6'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_a_q1", ia1.q, 8'h55); chk("hold_a_vld1", ia1.vld, 1'b0);
        end

        // Reset one cycle after a read; write under reset must be dropped
        drv1(1, 0, 6'h01, 8'h00);
        tick();
        rst = 1'b1;
        drv1(1, 1, 6'h01, 8'h99);
        tick();
        chk("mrst_b_vld1", ib1.vld, 1'b0); chk("mrst_b_q1", ib1.q, 8'h00);
        chk("mrst_a_vld1", ia1.vld, 1'b0); chk("mrst_a_q1", ia1.q, 8'h00);
        tick();
        chk("mrst2_b_vld1", ib1.vld, 1'b0); chk("mrst2_b_q1", ib1.q, 8'h00);
        rst = 1'b0;
        drv1(1, 0, 6'h01, 8'h00);
        tick();
        chk("post_a_q1", ia1.q, 8'h33); chk("post_a_vld1", ia1.vld, 1'b1);
        chk("post_b_vld1_early", ib1.vld, 1'b0);
        drv1(0, 0, 6'h00, 8'h00);
        tick();
        chk("post_b_q1", ib1.q, 8'h33); chk("post_b_vld1", ib1.vld, 1'b1);

        // 16-bit: collision with lane priority
        drvw1(1, 1, 2'b01, 6'h10, 16'hAAAA); drvw2(1, 1, 2'b11, 6'h10, 16'hBBBB);
        tick();
        chk("w_coll_hi", coll_w, 1'b1);
        drvw1(1, 0, 2'b00, 6'h10, 16'h0); drvw2(0, 0, 2'b00, 6'h00, 16'h0);
        tick();
        chk("w_coll_lo", coll_w, 1'b0);
        chk("w_coll_data", iw1.q, 16'hBBAA);
        // Writes at the two address extremes: no collision
        drvw1(1, 1, 2'b11, 6'h3F, 16'h1234); drvw2(1, 1, 2'b11, 6'h00, 16'h5678);
        tick();
        chk("w_nocoll", coll_w, 1'b0);
        drvw1(1, 1, 2'b10, 6'h3F, 16'hCDEF); drvw2(1, 0, 2'b00, 6'h00, 16'h0);
        tick();
        chk("w_adr0_q2", iw2.q, 16'h5678);
        drvw1(1, 0, 2'b00, 6'h3F, 16'h0); drvw2(0, 0, 2'b00, 6'h00, 16'h0);
        tick();
        chk("w_lane_hi_q1", iw1.q, 16'hCD34);
        drvw1(1, 1, 2'b00, 6'h3F, 16'hFFFF);
        tick();
        drvw1(1, 0, 2'b00, 6'h3F, 16'h0);
        tick();
        chk("w_be0_q1", iw1.q, 16'hCD34);
        drvw1(0, 0, 2'b00, 6'h00, 16'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
Parametrised successor to the fixed 8x64 dual-port RAM. It is a true dual-port synchronous RAM, generalised in data width and depth.
- Adds per-port enables and byte-lane write enables.
- Same-port read-during-write mode is selectable.
- Output register stage is optional; read-valid flags and a write-collision flag are provided.
- Used as a shared buffer between two independent agents on one clock domain.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8
ADDR_W, 6, address width; depth = 2**ADDR_W words
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en1  in  1  port 1 access enable
we1  in  1  port 1 write enable (qualified by en1)
be1  in  DATA_W/8  port 1 byte-lane enables for writes
adr1  in  ADDR_W  port 1 address
data1  in  DATA_W  port 1 write data
q1  out  DATA_W  port 1 read data
vld1  out  1  port 1 read data valid
en2, we2, be2, adr2, data2, q2, vld2: port 2, identical to port 1
collision  out  1  pulse: both ports wrote the same address

Behaviour:
- Reset values:
  - q1, q2, vld1, vld2, collision = 0 on the cycle after rst is sampled high.
  - Memory array is not initialised.
  - While rst is high, writes are suppressed and all pipeline stages are flushed.
- Access:
  - Every enabled access (en=1) is a read of adr, including write cycles.
  - en=0: no read, no write; q holds its last value; vld deasserts at the normal latency.
- Latency:
  - OUT_REG=0: q and vld update at edge N+1 for an access at edge N.
  - OUT_REG=1: q and vld update at edge N+2.
  - The vld pipeline is exactly as deep as the data pipeline.
- Byte writes: lane k (bits 8k+7:8k) is written only when we=1 and be[k]=1. Lanes with be[k]=0 keep their old contents. we=1 with be all zero writes nothing.
- Same-port read-during-write:
  - RDW_MODE=0: q returns the pre-write word.
  - RDW_MODE=1: q returns the merged word (new bytes on enabled lanes, old bytes elsewhere).
- Cross-port read-during-write (port x reads the address port y writes in the same cycle): the reader always gets the pre-write word, regardless of RDW_MODE.
- Write collision (en1 & we1 & en2 & we2 & adr1==adr2):
  - Per lane, port 1 wins where be1[k]=1; otherwise port 2's lane is written if be2[k]=1.
  - collision=1 for exactly one cycle at edge N+1; this is independent of OUT_REG.
  - Each port's own read data follows its RDW_MODE, using the final merged word for write-first.
- Back-to-back accesses: a new access is accepted every cycle per port with no bubbles. Address 0 and address 2**ADDR_W-1 behave identically to all others; there is no wrap logic.
- Reset mid-operation: in-flight reads are dropped. vld stays 0 until a new access completes its full latency after rst falls.

Decomposition:
- Package dpram_pkg holds:
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants;
  - a lane-merge function, merge(old, new, be), used by both the write path and write-first read data.
- One sub-module, dpram_out_stage, instantiated once per port: the optional output register plus vld pipeline, parametrised by DATA_W and OUT_REG, with synchronous reset.
- The memory array and collision logic stay in the top module.

Test Plan:
1. DATA_W=8, OUT_REG=0: write 0x33@0x01 on port 1 and 0x44@0x02 on port 2 in the same cycle, then read 0x01 on port 2 and 0x02 on port 1 -> q2=0x33, q1=0x44 one cycle after each read, vld high on those cycles.
2. Cross-port read-during-write: port 1 writes 0x55@0x03 while port 2 reads 0x03 (old value 0x00) -> q2=0x00; the next port 2 read of 0x03 returns 0x55.
3. Collision, DATA_W=16: port 1 writes 0xAAAA with be1=01, port 2 writes 0xBBBB with be2=11, both @0x10 -> collision=1 for one cycle; a later read returns 0xBBAA.
4. RDW_MODE=1, OUT_REG=1: port 1 writes 0x77@0x02 over old 0x44 -> q1=0x77 two cycles later. With RDW_MODE=0 the same stimulus gives q1=0x44.
5. Reset mid-operation, OUT_REG=1: assert rst one cycle after a read of 0x01 -> vld1 and q1 are 0. A write attempted while rst is high is not stored (a read after reset returns the old contents).
6. en1=0 for 3 cycles after a read of 0x55 -> q1 holds 0x55, vld1=0 on all three cycles.
